// File: rtl/ant_reg_arbiter.sv
// Round-robin write arbiter and zeroing-sweep sequencer for the ant-simulation register bank.
// Optional build macro ARB_LOCK_EN adds Req_Lock for back-to-back locked grants.
module ant_reg_arbiter #(
    parameter int N        = 16,
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                      Clk,
    input  logic                      Clr_n,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*ADDR_W-1:0] Req_Addr,
    input  logic [NUM_REQ*N-1:0]      Req_Data,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        Req_Lock,
`endif
    input  logic                      Clear_All,
    output logic [NUM_REQ-1:0]        Gnt,
    output logic [NUM_REGS-1:0]       Reg_Ld,
    output logic [N-1:0]              Reg_Data,
    output logic                      Addr_Err,
    output logic                      Busy,
    output logic                      Sweep_Done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REGS-1:0] ld_q;
    logic [N-1:0]        data_q;
    logic                err_q;
    logic                busy_q;
    logic                done_q;

    logic [NUM_REQ-1:0]  elig_s;
    logic [PTR_W:0]      sum_s;
    logic [PTR_W-1:0]    cand_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic                win_vld_s;
    logic [PTR_W-1:0]    lock_idx_s;
    logic                lock_hold_s;
    logic [PTR_W-1:0]    sel_idx_s;
    logic                sel_vld_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [N-1:0]        sel_data_s;
    logic                addr_ok_s;
    logic [NUM_REGS-1:0] ld_sel_s;
    logic [NUM_REQ-1:0]  gnt_sel_s;
    logic [PTR_W-1:0]    ptr_nxt_s;

    // Arbitration: pick the winner, its address decode and the next pointer.
    always_comb begin
        // A requester shown Gnt this cycle may still hold a stale Req, so it sits out.
        elig_s    = Req & ~gnt_q;
        sum_s     = {(PTR_W+1){1'b0}};
        cand_s    = {PTR_W{1'b0}};
        win_idx_s = {PTR_W{1'b0}};
        win_vld_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum_s     = {1'b0, ptr_q} + (PTR_W+1)'(k);
            cand_s    = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum_s - (PTR_W+1)'(NUM_REQ))
                                                      : sum_s[PTR_W-1:0];
            win_idx_s = elig_s[cand_s] ? cand_s : win_idx_s;
            win_vld_s = win_vld_s | elig_s[cand_s];
        end
        lock_idx_s  = {PTR_W{1'b0}};
        lock_hold_s = 1'b0;
`ifdef ARB_LOCK_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            lock_idx_s  = (gnt_q[i] & Req_Lock[i] & Req[i]) ? PTR_W'(i) : lock_idx_s;
            lock_hold_s = lock_hold_s | (gnt_q[i] & Req_Lock[i] & Req[i]);
        end
`endif
        sel_vld_s  = lock_hold_s | win_vld_s;
        sel_idx_s  = lock_hold_s ? lock_idx_s : win_idx_s;
        sel_addr_s = Req_Addr[32'(sel_idx_s)*ADDR_W +: ADDR_W];
        sel_data_s = Req_Data[32'(sel_idx_s)*N +: N];
        addr_ok_s  = (32'(sel_addr_s) < 32'(NUM_REGS));
        for (int r = 0; r < NUM_REGS; r++) begin
            ld_sel_s[r] = addr_ok_s & (sel_addr_s == ADDR_W'(r));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_sel_s[i] = (sel_idx_s == PTR_W'(i));
        end
        ptr_nxt_s = (sel_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : sel_idx_s + PTR_W'(1);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q <= ST_ARB;
            ptr_q   <= {PTR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            gnt_q   <= {NUM_REQ{1'b0}};
            ld_q    <= {NUM_REGS{1'b0}};
            data_q  <= {N{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (Clear_All) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= {CNT_W{1'b0}};
                        gnt_q   <= {NUM_REQ{1'b0}};
                        ld_q    <= {{(NUM_REGS-1){1'b0}}, 1'b1};
                        data_q  <= {N{1'b0}};
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        gnt_q   <= sel_vld_s ? gnt_sel_s : {NUM_REQ{1'b0}};
                        ld_q    <= sel_vld_s ? ld_sel_s : {NUM_REGS{1'b0}};
                        data_q  <= sel_vld_s ? sel_data_s : {N{1'b0}};
                        err_q   <= sel_vld_s & ~addr_ok_s;
                        ptr_q   <= sel_vld_s ? ptr_nxt_s : ptr_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    // ld_q already holds the one-hot for cnt_q; shifting walks the bank.
                    gnt_q  <= {NUM_REQ{1'b0}};
                    ld_q   <= {ld_q[NUM_REGS-2:0], 1'b0};
                    data_q <= {N{1'b0}};
                    err_q  <= 1'b0;
                    busy_q <= 1'b1;
                    if (cnt_q == CNT_W'(NUM_REGS - 2)) begin
                        state_q <= ST_ARB;
                        cnt_q   <= {CNT_W{1'b0}};
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                    cnt_q   <= {CNT_W{1'b0}};
                    gnt_q   <= {NUM_REQ{1'b0}};
                    ld_q    <= {NUM_REGS{1'b0}};
                    data_q  <= {N{1'b0}};
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Gnt        = gnt_q;
    assign Reg_Ld     = ld_q;
    assign Reg_Data   = data_q;
    assign Addr_Err   = err_q;
    assign Busy       = busy_q;
    assign Sweep_Done = done_q;

endmodule

// File: tb/tb_ant_reg_arbiter.sv
// Directed self-checking bench for ant_reg_arbiter: reset, fairness, single write,
// address error, sweep, reset mid-sweep, and locked grants when ARB_LOCK_EN is defined.
module tb_ant_reg_arbiter;

    localparam int N        = 16;
    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 4;

    logic                      Clk = 1'b0;
    logic                      Clr_n;
    logic [NUM_REQ-1:0]        Req;
    logic [NUM_REQ*ADDR_W-1:0] Req_Addr;
    logic [NUM_REQ*N-1:0]      Req_Data;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]        Req_Lock;
`endif
    logic                      Clear_All;
    logic [NUM_REQ-1:0]        Gnt;
    logic [NUM_REGS-1:0]       Reg_Ld;
    logic [N-1:0]              Reg_Data;
    logic                      Addr_Err;
    logic                      Busy;
    logic                      Sweep_Done;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 Clk = ~Clk;

    ant_reg_arbiter #(
        .N(N), .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk),
        .Clr_n(Clr_n),
        .Req(Req),
        .Req_Addr(Req_Addr),
        .Req_Data(Req_Data),
`ifdef ARB_LOCK_EN
        .Req_Lock(Req_Lock),
`endif
        .Clear_All(Clear_All),
        .Gnt(Gnt),
        .Reg_Ld(Reg_Ld),
        .Reg_Data(Reg_Data),
        .Addr_Err(Addr_Err),
        .Busy(Busy),
        .Sweep_Done(Sweep_Done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
        Req_Addr[i*ADDR_W +: ADDR_W] = a;
        Req_Data[i*N +: N]           = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(Gnt),        32'h0);
        chk({tag, "_ld"},   32'(Reg_Ld),     32'h0);
        chk({tag, "_data"}, 32'(Reg_Data),   32'h0);
        chk({tag, "_err"},  32'(Addr_Err),   32'h0);
        chk({tag, "_busy"}, 32'(Busy),       32'h0);
        chk({tag, "_done"}, 32'(Sweep_Done), 32'h0);
    endtask

    initial begin
        Clr_n     = 1'b0;
        Clear_All = 1'b0;
        Req       = 4'b1111;
        Req_Addr  = '0;
        Req_Data  = '0;
`ifdef ARB_LOCK_EN
        Req_Lock  = 4'b0000;
`endif
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), 16'hA000 + 16'(i));

        // Reset held with every request asserted
        step();
        step();
        chk_idle("reset");

        // Release; all four requesting -> strict rotation from requester 0
        Clr_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fair_gnt",  32'(Gnt),      32'(1) << (k % 4));
            chk("fair_ld",   32'(Reg_Ld),   32'(1) << (k % 4));
            chk("fair_data", 32'(Reg_Data), 32'(16'hA000 + 16'(k % 4)));
            chk("fair_err",  32'(Addr_Err), 32'h0);
        end
        Req = 4'b0000;
        step();
        chk("idle_gnt", 32'(Gnt), 32'h0);

        // Single write: requester 2 to register 5
        set_req(2, 4'd5, 16'hBEEF);
        Req = 4'b0100;
        step();
        chk("single_gnt",  32'(Gnt),      32'h4);
        chk("single_ld",   32'(Reg_Ld),   32'h20);
        chk("single_data", 32'(Reg_Data), 32'hBEEF);
        chk("single_err",  32'(Addr_Err), 32'h0);
        Req = 4'b0000;
        step();
        chk("single_nogrant", 32'(Gnt), 32'h0);

        // Out-of-range address still granted, no load strobe
        set_req(1, 4'd9, 16'h1234);
        Req = 4'b0010;
        step();
        chk("aerr_gnt", 32'(Gnt),      32'h2);
        chk("aerr_ld",  32'(Reg_Ld),   32'h0);
        chk("aerr_err", 32'(Addr_Err), 32'h1);
        Req = 4'b0000;
        step();
        chk("aerr_clear", 32'(Addr_Err), 32'h0);
        Req = 4'b0110;
        step();
        chk("aerr_next_gnt", 32'(Gnt),    32'h4);
        chk("aerr_next_ld",  32'(Reg_Ld), 32'h20);
        Req = 4'b0000;
        step();

        // Clear_All beats a simultaneous request; mid-sweep Clear_All ignored
        Req       = 4'b0001;
        Clear_All = 1'b1;
        step();
        Clear_All = 1'b0;
        chk("sweep0_gnt",  32'(Gnt),        32'h0);
        chk("sweep0_ld",   32'(Reg_Ld),     32'h1);
        chk("sweep0_busy", 32'(Busy),       32'h1);
        chk("sweep0_done", 32'(Sweep_Done), 32'h0);
        for (int k = 1; k < NUM_REGS; k++) begin
            if (k == 3) Clear_All = 1'b1;
            step();
            Clear_All = 1'b0;
            chk("sweep_ld",   32'(Reg_Ld),     32'(1) << k);
            chk("sweep_data", 32'(Reg_Data),   32'h0);
            chk("sweep_gnt",  32'(Gnt),        32'h0);
            chk("sweep_busy", 32'(Busy),       32'h1);
            chk("sweep_done", 32'(Sweep_Done), (k == NUM_REGS - 1) ? 32'h1 : 32'h0);
        end
        step();
        chk("post_sweep_gnt",  32'(Gnt),        32'h1);
        chk("post_sweep_ld",   32'(Reg_Ld),     32'h1);
        chk("post_sweep_data", 32'(Reg_Data),   32'hA000);
        chk("post_sweep_busy", 32'(Busy),       32'h0);
        chk("post_sweep_done", 32'(Sweep_Done), 32'h0);
        Req = 4'b0000;
        step();

        // Move the pointer to 3, start a sweep, then reset in the middle of it
        Req = 4'b0100;
        step();
        chk("pre_rst_gnt", 32'(Gnt), 32'h4);
        Req       = 4'b0000;
        Clear_All = 1'b1;
        step();
        Clear_All = 1'b0;
        chk("pre_rst_busy", 32'(Busy), 32'h1);
        step();
        chk("pre_rst_ld", 32'(Reg_Ld), 32'h2);
        Clr_n = 1'b0;
        #1;
        chk_idle("midsweep_rst");
        Clr_n = 1'b1;
        Req   = 4'b1010;
        step();
        chk("rst_ptr_gnt", 32'(Gnt),      32'h2);
        chk("rst_ptr_err", 32'(Addr_Err), 32'h1);
        Req = 4'b0000;
        step();

`ifdef ARB_LOCK_EN
        // Locked requester 3 re-granted back-to-back while others wait
        Req      = 4'b1000;
        Req_Lock = 4'b1000;
        step();
        chk("lock_gnt0", 32'(Gnt), 32'h8);
        Req = 4'b1111;
        for (int k = 1; k < 5; k++) begin
            step();
            chk("lock_gnt", 32'(Gnt), 32'h8);
        end
        Req_Lock = 4'b0000;
        step();
        chk("unlock_gnt", 32'(Gnt), 32'h1);
        Req = 4'b0000;
        step();
        Req      = 4'b1000;
        Req_Lock = 4'b1000;
        step();
        step();
        chk("lock2_gnt", 32'(Gnt), 32'h8);
        Clr_n = 1'b0;
        #1;
        chk_idle("lock_rst");
        Clr_n    = 1'b1;
        Req      = 4'b0000;
        Req_Lock = 4'b0000;
        step();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
